// File: rtl/mig_app_pkg.sv
// Shared types for the MIG app-interface responder.
// Command encodings, responder FSM states and the stall LFSR seed.
package mig_app_pkg;

    typedef enum logic [2:0] {
        APP_CMD_WRITE = 3'b000,
        APP_CMD_READ  = 3'b001
    } app_cmd_t;

    typedef enum logic [1:0] {
        CALIB,
        READY,
        WR_PEND
    } resp_state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/mig_app_responder_fifo.sv
// sync_fifo: single-clock FIFO, synchronous active-high reset.
// Ports: i_push/i_din write side, i_pop/o_dout read side (show-ahead),
// o_full/o_empty status. DEPTH must be a power of two (>= 2).
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wp;
    logic [AW:0]      r_rp;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer bit tells full from empty when indices match.
    assign o_empty   = (r_wp == r_rp);
    assign o_full    = (r_wp[AW] != r_rp[AW]) &&
                       (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign o_dout    = r_mem[r_rp[AW-1:0]];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_do_push) r_wp <= r_wp + (AW+1)'(1);
            if (w_do_pop)  r_rp <= r_rp + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wp[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/mig_app_responder.sv
// mig_app_responder: RAM-backed stand-in for the MIG 7-series app_* port.
// Ports: ui_clk/ui_clk_sync_rst; app_addr/app_cmd/app_en/app_rdy command;
// app_wdf_* write data; app_rd_data* read return; init_calib_complete;
// illegal_cmd_o sticky error. Define MIG_APP_STALL_INJECT_EN to add
// LFSR-driven pseudo-random app_rdy / app_wdf_rdy backpressure.
module mig_app_responder
    import mig_app_pkg::*;
#(
    parameter int WORD_SIZE      = 128,
    parameter int ADDR_WIDTH     = 29,
    parameter int MEM_DEPTH_LOG2 = 10,
    parameter int RD_LATENCY     = 8,
    parameter int CALIB_CYCLES   = 64,
    parameter int WDF_DEPTH      = 4
) (
    input  logic                   ui_clk,
    input  logic                   ui_clk_sync_rst,
    input  logic [ADDR_WIDTH-1:0]  app_addr,
    input  logic [2:0]             app_cmd,
    input  logic                   app_en,
    output logic                   app_rdy,
    input  logic [WORD_SIZE-1:0]   app_wdf_data,
    input  logic [WORD_SIZE/8-1:0] app_wdf_mask,
    input  logic                   app_wdf_wren,
    input  logic                   app_wdf_end,
    output logic                   app_wdf_rdy,
    output logic [WORD_SIZE-1:0]   app_rd_data,
    output logic                   app_rd_data_valid,
    output logic                   app_rd_data_end,
    output logic                   init_calib_complete,
    output logic                   illegal_cmd_o
);
    localparam int MW = WORD_SIZE / 8;
    localparam int FW = WORD_SIZE + MW;
    localparam int L  = MEM_DEPTH_LOG2;
    localparam int CW = $clog2(CALIB_CYCLES + 1);
    localparam int PL = RD_LATENCY - 1;

    resp_state_t          r_state;
    logic [CW-1:0]        r_cnt;
    logic                 r_calib;
    logic                 r_ill;
    logic [L-1:0]         r_pend_idx;
    logic [WORD_SIZE-1:0] r_mem [2**L];
    logic                 r_rq_v;
    logic [WORD_SIZE-1:0] r_rq_d;
    logic                 r_pv [PL];
    logic [WORD_SIZE-1:0] r_pd [PL];

    logic                 w_stall_cmd;
    logic                 w_stall_wdf;
    logic                 w_cmd_acc;
    logic                 w_wd_acc;
    logic                 w_is_wr;
    logic                 w_is_rd;
    logic                 w_wr_cmd;
    logic                 w_rd_cmd;
    logic                 w_ill;
    logic                 w_pop;
    logic                 w_bypass;
    logic                 w_push;
    logic                 w_wr_en;
    logic [L-1:0]         w_addr_idx;
    logic [L-1:0]         w_wr_idx;
    logic [WORD_SIZE-1:0] w_wr_data;
    logic [MW-1:0]        w_wr_mask;
    logic [FW-1:0]        w_fifo_dout;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic                 w_unused;

`ifdef MIG_APP_STALL_INJECT_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0],
                       r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end

    assign w_stall_cmd = (r_lfsr[1:0] == 2'b00);
    assign w_stall_wdf = (r_lfsr[3:2] == 2'b00);
`else
    assign w_stall_cmd = 1'b0;
    assign w_stall_wdf = 1'b0;
`endif

    assign app_rdy     = (r_state == READY) && !w_stall_cmd;
    assign app_wdf_rdy = r_calib && !w_fifo_full && !w_stall_wdf;

    assign w_cmd_acc  = app_en && app_rdy;
    assign w_wd_acc   = app_wdf_wren && app_wdf_rdy;
    assign w_is_wr    = (app_cmd == APP_CMD_WRITE);
    assign w_is_rd    = (app_cmd == APP_CMD_READ);
    assign w_wr_cmd   = w_cmd_acc && w_is_wr;
    assign w_rd_cmd   = w_cmd_acc && w_is_rd;
    assign w_ill      = w_cmd_acc && !w_is_wr && !w_is_rd;
    assign w_addr_idx = app_addr[3 +: L];

    // Buffered data is consumed first; an incoming beat goes straight
    // to RAM only when nothing older is waiting for it.
    assign w_pop    = w_wr_cmd && !w_fifo_empty;
    assign w_bypass = w_wd_acc &&
                      ((w_wr_cmd && w_fifo_empty) || (r_state == WR_PEND));
    assign w_push   = w_wd_acc && !w_bypass;
    assign w_wr_en  = w_pop || w_bypass;

    assign w_wr_idx  = (r_state == WR_PEND) ? r_pend_idx : w_addr_idx;
    assign w_wr_data = w_pop ? w_fifo_dout[WORD_SIZE-1:0] : app_wdf_data;
    assign w_wr_mask = w_pop ? w_fifo_dout[FW-1:WORD_SIZE] : app_wdf_mask;

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (WDF_DEPTH)
    ) u_wdf (
        .clk     (ui_clk),
        .i_rst   (ui_clk_sync_rst),
        .i_push  (w_push),
        .i_din   ({app_wdf_mask, app_wdf_data}),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            r_state    <= CALIB;
            r_cnt      <= '0;
            r_calib    <= 1'b0;
            r_ill      <= 1'b0;
            r_pend_idx <= '0;
        end else begin
            case (r_state)
                CALIB: begin
                    if (r_cnt == CW'(CALIB_CYCLES - 1)) begin
                        r_state <= READY;
                        r_calib <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                READY: begin
                    if (w_wr_cmd && w_fifo_empty && !w_wd_acc) begin
                        r_pend_idx <= w_addr_idx;
                        r_state    <= WR_PEND;
                    end
                end
                WR_PEND: begin
                    if (w_wd_acc) r_state <= READY;
                end
                default: r_state <= CALIB;
            endcase
            if (w_ill) r_ill <= 1'b1;
        end
    end

    // Byte lanes with mask=1 keep their old contents.
    always_ff @(posedge ui_clk) begin
        if (w_wr_en) begin
            for (int b = 0; b < MW; b++) begin
                if (!w_wr_mask[b]) begin
                    r_mem[w_wr_idx][b*8 +: 8] <= w_wr_data[b*8 +: 8];
                end
            end
        end
    end

    // Registered RAM read plus RD_LATENCY-1 delay stages.
    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            r_rq_v <= 1'b0;
            r_rq_d <= '0;
            for (int i = 0; i < PL; i++) begin
                r_pv[i] <= 1'b0;
                r_pd[i] <= '0;
            end
        end else begin
            r_rq_v  <= w_rd_cmd;
            r_rq_d  <= r_mem[w_addr_idx];
            r_pv[0] <= r_rq_v;
            r_pd[0] <= r_rq_d;
            for (int i = 1; i < PL; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pd[i] <= r_pd[i-1];
            end
        end
    end

    assign app_rd_data         = r_pd[PL-1];
    assign app_rd_data_valid   = r_pv[PL-1];
    assign app_rd_data_end     = r_pv[PL-1];
    assign init_calib_complete = r_calib;
    assign illegal_cmd_o       = r_ill;

    assert property (@(posedge ui_clk) disable iff (ui_clk_sync_rst)
        app_wdf_end == app_wdf_wren);

    assign w_unused = ^{app_addr[2:0], app_addr[ADDR_WIDTH-1:3+L]};

endmodule

// File: tb/tb_mig_app_responder.sv
// Directed bench for mig_app_responder.
// Linear step sequence, immediate-assertion checks, one summary line.
module tb_mig_app_responder;

    logic         ui_clk = 1'b0;
    logic         ui_clk_sync_rst;
    logic [28:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en;
    logic         app_rdy;
    logic [127:0] app_wdf_data;
    logic [15:0]  app_wdf_mask;
    logic         app_wdf_wren;
    logic         app_wdf_end;
    logic         app_wdf_rdy;
    logic [127:0] app_rd_data;
    logic         app_rd_data_valid;
    logic         app_rd_data_end;
    logic         init_calib_complete;
    logic         illegal_cmd_o;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [127:0] D1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] D2 = 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000;
    localparam logic [127:0] D3 = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;

    logic [127:0] beats [4];

    mig_app_responder dut (
        .ui_clk              (ui_clk),
        .ui_clk_sync_rst     (ui_clk_sync_rst),
        .app_addr            (app_addr),
        .app_cmd             (app_cmd),
        .app_en              (app_en),
        .app_rdy             (app_rdy),
        .app_wdf_data        (app_wdf_data),
        .app_wdf_mask        (app_wdf_mask),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_end         (app_wdf_end),
        .app_wdf_rdy         (app_wdf_rdy),
        .app_rd_data         (app_rd_data),
        .app_rd_data_valid   (app_rd_data_valid),
        .app_rd_data_end     (app_rd_data_end),
        .init_calib_complete (init_calib_complete),
        .illegal_cmd_o       (illegal_cmd_o)
    );

    always #5 ui_clk = ~ui_clk;

    task automatic tick();
        @(posedge ui_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic wdata(input logic on, input logic [127:0] d,
                         input logic [15:0] m);
        app_wdf_wren = on;
        app_wdf_end  = on;
        app_wdf_data = d;
        app_wdf_mask = m;
    endtask

    task automatic wr_now(input logic [28:0] a, input logic [127:0] d,
                          input logic [15:0] m);
        app_en = 1'b1; app_cmd = 3'b000; app_addr = a;
        wdata(1'b1, d, m);
        tick();
        app_en = 1'b0;
        wdata(1'b0, '0, '0);
    endtask

    task automatic do_read(input logic [28:0] a, input logic [127:0] exp,
                           input string tag);
        int cyc;
        app_en = 1'b1; app_cmd = 3'b001; app_addr = a;
        tick();
        app_en = 1'b0;
        cyc = 1;
        while (!app_rd_data_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        chk({tag, "_lat"}, 128'(cyc), 128'd8);
        chk({tag, "_data"}, app_rd_data, exp);
        chk({tag, "_end"}, 128'(app_rd_data_end), 128'd1);
    endtask

    initial begin
        int got;
        ui_clk_sync_rst = 1'b1;
        app_en = 1'b0; app_cmd = 3'b000; app_addr = '0;
        wdata(1'b0, '0, '0);
        repeat (3) tick();
        chk("rst_rdy", 128'(app_rdy), 128'd0);
        chk("rst_wdf_rdy", 128'(app_wdf_rdy), 128'd0);
        chk("rst_valid", 128'(app_rd_data_valid), 128'd0);
        chk("rst_calib", 128'(init_calib_complete), 128'd0);
        chk("rst_ill", 128'(illegal_cmd_o), 128'd0);
        chk("rst_data", app_rd_data, 128'd0);

        // Calibration: 64 edges after release, visible in cycle 65.
        ui_clk_sync_rst = 1'b0;
        repeat (63) tick();
        chk("calib_pre", 128'(init_calib_complete), 128'd0);
        chk("rdy_pre", 128'(app_rdy), 128'd0);
        tick();
        chk("calib_rise", 128'(init_calib_complete), 128'd1);
        chk("rdy_post", 128'(app_rdy), 128'd1);
        chk("wdf_rdy_post", 128'(app_wdf_rdy), 128'd1);
        repeat (36) tick();
        chk("calib_hold", 128'(init_calib_complete), 128'd1);

        // Write + read, latency check, address wrap/low-bit aliasing.
        wr_now(29'h40, D1, 16'h0000);
        do_read(29'h40, D1, "rd40");
        do_read(29'h2047, D1, "rd_wrap");

        // Byte mask.
        wr_now(29'h0, 128'd0, 16'h0000);
        wr_now(29'h0, {128{1'b1}}, 16'h00FF);
        do_read(29'h0, D2, "rd_mask");

        // Command before data.
        app_en = 1'b1; app_cmd = 3'b000; app_addr = 29'h80;
        tick();
        app_en = 1'b0;
        chk("pend_rdy0", 128'(app_rdy), 128'd0);
        repeat (9) tick();
        chk("pend_rdy_hold", 128'(app_rdy), 128'd0);
        wdata(1'b1, D3, 16'h0000);
        tick();
        wdata(1'b0, '0, '0);
        chk("pend_rdy1", 128'(app_rdy), 128'd1);
        do_read(29'h80, D3, "rd_pend");

        // Data ahead of commands fills the FIFO.
        for (int i = 0; i < 4; i++) begin
            beats[i] = {32'(i + 1), 32'hA5A5_0000, 32'(i * 7), 32'hC0DE_0000};
        end
        for (int i = 0; i < 4; i++) begin
            chk("fifo_rdy_fill", 128'(app_wdf_rdy), 128'd1);
            wdata(1'b1, beats[i], 16'h0000);
            tick();
        end
        wdata(1'b0, '0, '0);
        chk("fifo_full", 128'(app_wdf_rdy), 128'd0);
        for (int i = 0; i < 4; i++) begin
            app_en = 1'b1; app_cmd = 3'b000; app_addr = 29'(i * 8);
            tick();
        end
        app_en = 1'b0;
        chk("fifo_drained", 128'(app_wdf_rdy), 128'd1);
        for (int i = 0; i < 4; i++) begin
            app_en = 1'b1; app_cmd = 3'b001; app_addr = 29'(i * 8);
            tick();
        end
        app_en = 1'b0;
        got = 0;
        for (int c = 0; c < 20; c++) begin
            if (app_rd_data_valid && got < 4) begin
                chk("fifo_order", app_rd_data, beats[got]);
                got++;
            end
            tick();
        end
        chk("fifo_count", 128'(got), 128'd4);

        // Illegal command, sticky.
        app_en = 1'b1; app_cmd = 3'b010; app_addr = 29'h40;
        tick();
        app_en = 1'b0;
        chk("ill_set", 128'(illegal_cmd_o), 128'd1);
        repeat (5) tick();
        chk("ill_sticky", 128'(illegal_cmd_o), 128'd1);
        chk("ill_no_valid", 128'(app_rd_data_valid), 128'd0);

        // Reset with reads in flight drops them.
        for (int i = 0; i < 3; i++) begin
            app_en = 1'b1; app_cmd = 3'b001; app_addr = 29'h40;
            tick();
        end
        app_en = 1'b0;
        ui_clk_sync_rst = 1'b1;
        tick();
        ui_clk_sync_rst = 1'b0;
        got = 0;
        for (int c = 0; c < 20; c++) begin
            if (app_rd_data_valid) got++;
            tick();
        end
        chk("rst_drop", 128'(got), 128'd0);
        chk("rst_ill_clr", 128'(illegal_cmd_o), 128'd0);
        chk("rst_calib_clr", 128'(init_calib_complete), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
